// File: rtl/arbitro_rr.sv
// arbitro_rr: N-input FIFO arbiter (round-robin or fixed priority) with per-destination backpressure
//   clk          rising-edge system clock
//   reset        asynchronous, active-high
//   FIFO_empty   empty flag per input FIFO
//   Almost_full  almost-full flag per output FIFO
//   dest         packed head-word destination, channel i at [i*DEST_W +: DEST_W]
//   Pops         registered one-hot pop strobe to input FIFOs
//   Push         registered one-hot push strobe to output FIFOs, one cycle after Pops
//   active_ch    index of the channel being popped, valid when |Pops
//   idle         no pop and no push in progress
module arbitro_rr #(
    parameter int N_CH   = 4,
    parameter int DEST_W = 2,
    parameter int MODE   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          FIFO_empty,
    input  logic [N_CH-1:0]          Almost_full,
    input  logic [N_CH*DEST_W-1:0]   dest,
    output logic [N_CH-1:0]          Pops,
    output logic [N_CH-1:0]          Push,
    output logic [DEST_W-1:0]        active_ch,
    output logic                     idle
);
    logic [DEST_W-1:0] dv [N_CH];
    logic [N_CH-1:0]   elig;
    logic [DEST_W-1:0] ptr, sel, d;
    logic              found;

    // search order: upward from ptr in round-robin mode, from 0 in fixed-priority mode
    function automatic int rot(logic [DEST_W-1:0] p, int k);
        return MODE == 1 ? (int'(p) + k) % N_CH : k;
    endfunction

    // a channel popped this cycle still shows a stale empty flag, so it is masked
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            dv[i]   = dest[i*DEST_W +: DEST_W];
            elig[i] = !FIFO_empty[i] && (32'(dv[i]) < N_CH) && !Almost_full[dv[i]] && !Pops[i];
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && elig[rot(ptr, k)]) begin
                found = 1'b1;
                sel   = DEST_W'(rot(ptr, k));
            end
        end
    end

    // Push follows Pops by one cycle using the destination captured at grant time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Pops      <= '0;
            Push      <= '0;
            active_ch <= '0;
            ptr       <= '0;
            d         <= '0;
        end else begin
            Push <= |Pops ? N_CH'(1) << d : '0;
            Pops <= found ? N_CH'(1) << sel : '0;
            if (found) begin
                active_ch <= sel;
                d         <= dv[sel];
                if (MODE == 1)
                    ptr <= DEST_W'((int'(sel) + 1) % N_CH);
            end
        end
    end

    assign idle = ~|{Pops, Push};
endmodule

// File: tb/tb_arbitro_rr.sv
module tb_arbitro_rr;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] emp4 = 4'hF, af4 = 4'h0;
    logic [7:0] dest4 = 8'h00;
    logic [2:0] emp3 = 3'h7, af3 = 3'h0;
    logic [5:0] dest3 = 6'h00;
    logic [3:0] pops_r, push_r, pops_f, push_f;
    logic [2:0] pops_3, push_3;
    logic [1:0] act_r, act_f, act_3;
    logic       idle_r, idle_f, idle_3;
    int checks = 0, errors = 0;
    // reference model per instance: granted channel, pending push destination, pointer, captured destination
    int g[3], pd[3], pt[3], dd[3];
    int md[3] = '{1, 0, 1};
    int nn[3] = '{4, 4, 3};

    arbitro_rr #(.N_CH(4), .DEST_W(2), .MODE(1)) dut_rr (.clk(clk), .reset(reset), .FIFO_empty(emp4),
        .Almost_full(af4), .dest(dest4), .Pops(pops_r), .Push(push_r), .active_ch(act_r), .idle(idle_r));
    arbitro_rr #(.N_CH(4), .DEST_W(2), .MODE(0)) dut_fp (.clk(clk), .reset(reset), .FIFO_empty(emp4),
        .Almost_full(af4), .dest(dest4), .Pops(pops_f), .Push(push_f), .active_ch(act_f), .idle(idle_f));
    arbitro_rr #(.N_CH(3), .DEST_W(2), .MODE(1)) dut_3 (.clk(clk), .reset(reset), .FIFO_empty(emp3),
        .Almost_full(af3), .dest(dest3), .Pops(pops_3), .Push(push_3), .active_ch(act_3), .idle(idle_3));

    always #5 clk = ~clk;

    function automatic int dst(int m, int i);
        return m == 2 ? int'((dest3 >> (2 * i)) & 6'd3) : int'((dest4 >> (2 * i)) & 8'd3);
    endfunction

    function automatic int pick(int m);
        int i, di;
        logic [3:0] e, a;
        e = m == 2 ? {1'b1, emp3} : emp4;
        a = m == 2 ? {1'b0, af3} : af4;
        for (int k = 0; k < nn[m]; k++) begin
            i  = md[m] == 1 ? (pt[m] + k) % nn[m] : k;
            di = dst(m, i);
            if (!e[i] && di < nn[m] && !a[di] && i != g[m]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            g[m] = -1; pd[m] = -1; pt[m] = 0; dd[m] = 0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_one(int m, string tag, logic [3:0] po, logic [3:0] pu, logic [1:0] ac, logic id);
        chk({tag, "_pops"}, 32'(po), g[m] >= 0 ? 32'(1) << g[m] : 32'(0));
        chk({tag, "_push"}, 32'(pu), pd[m] >= 0 ? 32'(1) << pd[m] : 32'(0));
        chk({tag, "_idle"}, 32'(id), (g[m] < 0 && pd[m] < 0) ? 32'(1) : 32'(0));
        if (g[m] >= 0) chk({tag, "_active"}, 32'(ac), 32'(g[m]));
    endtask

    task automatic step(string tag);
        int ng[3];
        for (int m = 0; m < 3; m++) ng[m] = pick(m);
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            pd[m] = g[m] >= 0 ? dd[m] : -1;
            if (ng[m] >= 0) begin
                dd[m] = dst(m, ng[m]);
                if (md[m] == 1) pt[m] = (ng[m] + 1) % nn[m];
            end
            g[m] = ng[m];
        end
        chk_one(0, {tag, "_rr"}, pops_r, push_r, act_r, idle_r);
        chk_one(1, {tag, "_fp"}, pops_f, push_f, act_f, idle_f);
        chk_one(2, {tag, "_n3"}, {1'b0, pops_3}, {1'b0, push_3}, act_3, idle_3);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2;
        chk("por_pops", 32'(pops_r), 0);
        chk("por_push", 32'(push_r), 0);
        chk("por_idle", 32'(idle_r), 1);
        #10;
        reset = 1'b0;
        emp3 = 3'b011;
        dest3 = 6'b110000;
        // asynchronous reset while channel 1 is being popped
        emp4 = 4'b1101;
        step("one");
        chk("pre_rst_pops", 32'(pops_r), 32'b0010);
        chk("pre_rst_act", 32'(act_r), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_pops_rr", 32'(pops_r), 0);
        chk("async_pops_fp", 32'(pops_f), 0);
        chk("async_push", 32'(push_r), 0);
        chk("async_act", 32'(act_r), 0);
        chk("async_idle", 32'(idle_r), 1);
        model_reset();
        emp4 = 4'hF;
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step("post_rst");
        // single input holding a single word
        emp4 = 4'b1110;
        dest4 = 8'h02;
        step("single1");
        chk("single_pop", 32'(pops_r), 32'b0001);
        emp4 = 4'hF;
        step("single2");
        chk("single_push", 32'(push_r), 32'b0100);
        chk("single_nopop", 32'(pops_r), 0);
        step("single3");
        chk("oor_idle", 32'(idle_3), 1);
        // all inputs busy, all to destination 3
        apply_reset();
        emp4 = 4'h0;
        dest4 = 8'hFF;
        af4 = 4'h0;
        for (int k = 0; k < 8; k++) begin
            step("fair");
            chk("rr_seq", 32'(pops_r), 32'(1) << (k % 4));
            chk("fp_seq", 32'(pops_f), (k % 2) ? 32'd2 : 32'd1);
            if (k > 0) chk("rr_push", 32'(push_r), 32'b1000);
        end
        // per-destination backpressure
        emp4 = 4'b1100;
        dest4 = 8'h09;
        af4 = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step("bp");
            chk("bp_no_ch0", 32'(pops_f[0]), 0);
        end
        af4 = 4'h0;
        step("bp_rel");
        chk("bp_release", 32'(pops_f), 32'b0001);
        step("bp_rel2");
        chk("bp_push", 32'(push_f), 32'b0010);
        for (int k = 0; k < 4; k++) begin
            step("oor");
            chk("oor_pops", 32'(pops_3), 0);
        end
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            emp4  = 4'($urandom);
            af4   = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
            dest4 = 8'($urandom);
            emp3  = 3'($urandom);
            af3   = ($urandom % 3 == 0) ? 3'($urandom) : 3'h0;
            dest3 = 6'($urandom);
            if ($urandom % 60 == 0) apply_reset();
            step("rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
